// File: rtl/dcache_core_responder.sv
// dcache_core_responder: responder end of the core data-side request bus.
// Writes are acknowledged immediately and parked in a posted write buffer
// that drains to the memory port one entry at a time. Reads wait for the
// buffer to drain, fetch over the same memory port and are returned on a
// response channel that holds until the core consumes it.
module dcache_core_responder #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       reqcyc,
  input  logic [63:0]                req,
  input  logic [63:0]                reqdata,
  input  logic [TAG_W-1:0]           reqtag,
  output logic                       reqack,
  output logic                       respcyc,
  output logic [63:0]                resp,
  output logic [TAG_W-1:0]           resptag,
  input  logic                       respack,
  output logic                       mem_reqcyc,
  output logic [63:0]                mem_addr,
  output logic [63:0]                mem_wdata,
  output logic                       mem_we,
  input  logic                       mem_ack,
  input  logic [63:0]                mem_rdata,
  output logic [$clog2(DEPTH+1)-1:0] wbuf_count,
  output logic                       wbuf_full
);
  localparam int DATA_W = 64;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, RD_DRAIN, RD_MEM, RESP} state_t;
  state_t state, state_next;

  logic [DATA_W-1:0] buf_addr [DEPTH];
  logic [DATA_W-1:0] buf_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              wr_active;
  logic [DATA_W-1:0] rd_addr, rd_data;
  logic [TAG_W-1:0]  rd_tag;

  logic can_take, accept_wr, accept_rd, pop, drain_start;

  // Only the WRITE bit of the tag is decoded; a request presented while the
  // previous accept pulse is still high is the same request and is ignored.
  // Fullness uses the current count, so a same-cycle pop frees its slot one
  // cycle later. A drain may start on the very edge that pushes into an
  // empty buffer, so the first write reaches memory together with reqack.
  assign can_take    = reqcyc && !reqack && (state == IDLE);
  assign accept_wr   = can_take && reqtag[TAG_W-1] && !wbuf_full;
  assign accept_rd   = can_take && !reqtag[TAG_W-1];
  assign pop         = wr_active && mem_ack;
  assign drain_start = !wr_active && (state != RD_MEM) &&
                       ((count != '0) || accept_wr);

  assign wbuf_count = count;
  assign wbuf_full  = (count == CNT_W'(DEPTH));

  // Control state: FSM register, accept pulse, buffer pointers/count, drain flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      reqack    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_active <= 1'b0;
    end else begin
      state  <= state_next;
      reqack <= accept_wr || accept_rd;
      if (accept_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)       rd_ptr <= rd_ptr + PTR_W'(1);
      if (accept_wr && !pop)      count <= count + CNT_W'(1);
      else if (!accept_wr && pop) count <= count - CNT_W'(1);
      if (pop)              wr_active <= 1'b0;
      else if (drain_start) wr_active <= 1'b1;
    end
  end

  // Payload storage: buffer entries, latched read request and returned data.
  always_ff @(posedge clk) begin
    if (accept_wr) begin
      buf_addr[wr_ptr] <= req;
      buf_data[wr_ptr] <= reqdata;
    end
    if (accept_rd) begin
      rd_addr <= req;
      rd_tag  <= reqtag;
    end
    if ((state == RD_MEM) && mem_ack) rd_data <= mem_rdata;
  end

  // Read FSM next state: wait for the buffer and port to go quiet, fetch, hold.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept_rd) state_next = RD_DRAIN;
      RD_DRAIN: if ((count == '0) && !wr_active) state_next = RD_MEM;
      RD_MEM:   if (mem_ack) state_next = RESP;
      RESP:     if (respack) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Output muxing: write drain and read fetch never overlap; idle outputs are 0.
  always_comb begin
    mem_reqcyc = wr_active || (state == RD_MEM);
    mem_we     = wr_active;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (wr_active) begin
      mem_addr  = buf_addr[rd_ptr];
      mem_wdata = buf_data[rd_ptr];
    end else if (state == RD_MEM) begin
      mem_addr = rd_addr;
    end
    respcyc = (state == RESP);
    resp    = respcyc ? rd_data : '0;
    resptag = respcyc ? rd_tag : '0;
  end

endmodule

// File: tb/tb_dcache_core_responder.sv
// Bench for dcache_core_responder: a memory responder process, hand-written
// corner sequences, a table of request/expected-response records and a
// randomized run against a core-side memory-image model.
module tb_dcache_core_responder;
  localparam int DEPTH = 4;
  localparam int TAG_W = 10;
  localparam logic [63:0] KDEF = 64'h5A5A_5A5A_5A5A_5A5A;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              reqcyc = 1'b0;
  logic [63:0]       req = '0;
  logic [63:0]       reqdata = '0;
  logic [TAG_W-1:0]  reqtag = '0;
  logic              reqack;
  logic              respcyc;
  logic [63:0]       resp;
  logic [TAG_W-1:0]  resptag;
  logic              respack = 1'b0;
  logic              mem_reqcyc;
  logic [63:0]       mem_addr;
  logic [63:0]       mem_wdata;
  logic              mem_we;
  logic              mem_ack = 1'b0;
  logic [63:0]       mem_rdata = '0;
  logic [2:0]        wbuf_count;
  logic              wbuf_full;

  always #5 clk = ~clk;

  dcache_core_responder #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .reqcyc(reqcyc), .req(req), .reqdata(reqdata),
    .reqtag(reqtag), .reqack(reqack), .respcyc(respcyc), .resp(resp),
    .resptag(resptag), .respack(respack), .mem_reqcyc(mem_reqcyc),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wbuf_count(wbuf_count),
    .wbuf_full(wbuf_full)
  );

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] data;
  } mtx_t;

  typedef struct {
    bit               we;
    logic [63:0]      addr;
    logic [63:0]      data;
    logic [TAG_W-1:0] tag;
    logic [63:0]      exp_resp;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   mem_lat = 1;
  bit   mem_hold = 1'b0;
  int   wait_cnt = 0;
  mtx_t mem_log[$];
  logic [63:0] bfm_mem [logic [63:0]];

  // Memory responder: acks after mem_lat request cycles unless held.
  initial begin
    forever begin
      @(negedge clk);
      if (reset || mem_ack || !mem_reqcyc) begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
        if (!mem_hold && wait_cnt >= mem_lat) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          mem_log.push_back('{mem_we, mem_addr, mem_wdata});
          if (mem_we) begin
            bfm_mem[mem_addr] = mem_wdata;
            mem_rdata = '0;
          end else begin
            mem_rdata = bfm_mem.exists(mem_addr) ? bfm_mem[mem_addr] : (mem_addr ^ KDEF);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] d,
                      input logic [TAG_W-1:0] t, input int bound, output bit ok);
    reqcyc = 1'b1; req = a; reqdata = d; reqtag = t; ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      tick();
      if (reqack) ok = 1'b1;
    end
    reqcyc = 1'b0;
  endtask

  task automatic get_resp(input int delay, output logic [63:0] r, output logic [TAG_W-1:0] t);
    bit stable;
    stable = 1'b1;
    for (int i = 0; i < 100 && !respcyc; i++) tick();
    chk("resp_valid", respcyc, 1);
    r = resp; t = resptag;
    for (int j = 0; j < delay; j++) begin
      tick();
      if (!respcyc || resp !== r || resptag !== t) stable = 1'b0;
    end
    if (delay > 0) chk("resp_stable", stable, 1);
    respack = 1'b1;
    tick();
    respack = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      tick();
      idle = (wbuf_count == 0) && !mem_reqcyc && !respcyc;
    end
    chk(nm, idle, 1);
  endtask

  vec_t             tbl[9];
  bit               ok, any, stable;
  logic [63:0]      r, a, d, exp;
  logic [TAG_W-1:0] t;
  logic [63:0]      ref_mem [logic [63:0]];
  logic [63:0]      exp_wr[$];
  logic [63:0]      got_wr[$];

  initial begin
    tbl[0] = '{1'b1, 64'h4000, 64'h1111_2222_3333_4444, 10'h201, 64'h0};
    tbl[1] = '{1'b1, 64'h4008, 64'hAAAA_BBBB_CCCC_DDDD, 10'h202, 64'h0};
    tbl[2] = '{1'b0, 64'h4000, 64'h0, 10'h003, 64'h1111_2222_3333_4444};
    tbl[3] = '{1'b1, 64'h4000, 64'h0123_4567_89AB_CDEF, 10'h2FF, 64'h0};
    tbl[4] = '{1'b0, 64'h4000, 64'h0, 10'h1C4, 64'h0123_4567_89AB_CDEF};
    tbl[5] = '{1'b0, 64'h4008, 64'h0, 10'h0A5, 64'hAAAA_BBBB_CCCC_DDDD};
    tbl[6] = '{1'b0, 64'h4010, 64'h0, 10'h17F, 64'h5A5A_5A5A_5A5A_1A4A};
    tbl[7] = '{1'b1, 64'h4010, 64'hFFFF_FFFF_FFFF_FFFF, 10'h3FF, 64'h0};
    tbl[8] = '{1'b0, 64'h4010, 64'h0, 10'h000, 64'hFFFF_FFFF_FFFF_FFFF};

    // Reset state
    tick(); tick(); tick();
    chk("rst_ctrl_outs", {reqack, respcyc, mem_reqcyc, mem_we, wbuf_full}, 0);
    chk("rst_count", wbuf_count, 0);
    chk("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;
    tick();

    // Single write: accept latency, drain on same cycle as reqack, pop on ack
    mem_lat = 2;
    mem_log.delete();
    reqcyc = 1'b1; req = 64'h1000; reqdata = 64'hDEADBEEF_00000001; reqtag = 10'h200;
    tick();
    chk("w1_reqack", reqack, 1);
    chk("w1_count1", wbuf_count, 1);
    chk("w1_mem_reqcyc", mem_reqcyc, 1);
    chk("w1_mem_we", mem_we, 1);
    chk("w1_mem_addr", mem_addr, 64'h1000);
    chk("w1_mem_wdata", mem_wdata, 64'hDEADBEEF_00000001);
    reqcyc = 1'b0;
    tick();
    chk("w1_reqack_pulse", reqack, 0);
    chk("w1_mem_hold", mem_reqcyc, 1);
    tick();
    chk("w1_count0", wbuf_count, 0);
    chk("w1_mem_drop", mem_reqcyc, 0);
    chk("w1_log_n", mem_log.size(), 1);

    // Five writes with memory held off: fifth waits on a full buffer
    mem_hold = 1'b1; mem_lat = 1;
    mem_log.delete();
    for (int i = 0; i < 4; i++) begin
      send(64'h6000 + 64'(8 * i), 64'hF000 + 64'(i), 10'h200, 10, ok);
      chk("full_acc", ok, 1);
    end
    chk("full_flag", wbuf_full, 1);
    chk("full_count", wbuf_count, 4);
    reqcyc = 1'b1; req = 64'h6020; reqdata = 64'hF004; reqtag = 10'h200;
    any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (reqack) any = 1'b1;
    end
    chk("full_no_ack", any, 0);
    chk("full_flag_held", wbuf_full, 1);
    mem_hold = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (reqack) ok = 1'b1;
    end
    reqcyc = 1'b0;
    chk("full_fifth_acc", ok, 1);
    wait_idle("full_drain");
    chk("full_log_n", mem_log.size(), 5);
    for (int i = 0; i < 5 && i < mem_log.size(); i++) begin
      chk("full_order_addr", mem_log[i].addr, 64'h6000 + 64'(8 * i));
      chk("full_order_data", mem_log[i].data, 64'hF000 + 64'(i));
    end

    // Read ordered behind two buffered writes to the same address
    mem_lat = 3;
    mem_log.delete();
    send(64'h2000, 64'hAAAA_0000_0000_0001, 10'h200, 10, ok);
    chk("ord_w1", ok, 1);
    send(64'h2000, 64'hBBBB_0000_0000_0002, 10'h200, 10, ok);
    chk("ord_w2", ok, 1);
    send(64'h2000, 64'h0, 10'h195, 10, ok);
    chk("ord_rd_acc", ok, 1);
    any = 1'b0; stable = 1'b1;
    for (int i = 0; i < 80 && !respcyc; i++) begin
      tick();
      if (mem_reqcyc && !mem_we) begin
        any = 1'b1;
        if (wbuf_count != 0 || mem_log.size() < 2) stable = 1'b0;
      end
    end
    chk("ord_rd_seen", any, 1);
    chk("ord_rd_after_writes", stable, 1);
    get_resp(0, r, t);
    chk("ord_resp", r, 64'hBBBB_0000_0000_0002);
    chk("ord_resptag", t, 10'h195);

    // Held response with a write presented during the hold window
    mem_lat = 2;
    send(64'h3000, 64'h0, 10'h0C7, 10, ok);
    chk("hold_rd_acc", ok, 1);
    for (int i = 0; i < 50 && !respcyc; i++) tick();
    chk("hold_respcyc", respcyc, 1);
    chk("hold_resp", resp, 64'h5A5A_5A5A_5A5A_6A5A);
    chk("hold_resptag", resptag, 10'h0C7);
    r = resp; t = resptag;
    reqcyc = 1'b1; req = 64'h3008; reqdata = 64'h1234; reqtag = 10'h200;
    any = 1'b0; stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (reqack) any = 1'b1;
      if (!respcyc || resp !== r || resptag !== t) stable = 1'b0;
    end
    chk("hold_stable", stable, 1);
    chk("hold_no_wr_ack", any, 0);
    respack = 1'b1;
    tick();
    respack = 1'b0;
    chk("hold_resp_drop", respcyc, 0);
    ok = reqack;
    for (int i = 0; i < 3 && !ok; i++) begin
      tick();
      if (reqack) ok = 1'b1;
    end
    reqcyc = 1'b0;
    chk("hold_wr_after", ok, 1);
    wait_idle("hold_drain");

    // Reset with three buffered writes and a read waiting for the drain
    mem_hold = 1'b1; mem_lat = 1;
    for (int i = 0; i < 3; i++) begin
      send(64'h5000 + 64'(8 * i), 64'hE0 + 64'(i), 10'h200, 10, ok);
      chk("mrst_wr_acc", ok, 1);
    end
    send(64'h5000, 64'h0, 10'h011, 10, ok);
    chk("mrst_rd_acc", ok, 1);
    tick();
    reset = 1'b1;
    tick();
    chk("mrst_ctrl_outs", {reqack, respcyc, mem_reqcyc, mem_we, wbuf_full}, 0);
    chk("mrst_count", wbuf_count, 0);
    chk("mrst_data_outs", mem_addr | mem_wdata | resp, 0);
    tick();
    reset = 1'b0;
    mem_hold = 1'b0;
    mem_log.delete();
    any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_reqcyc) any = 1'b1;
    end
    chk("mrst_no_mem", any, 0);
    chk("mrst_log_empty", mem_log.size(), 0);

    // Table of request records
    mem_lat = 2;
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].addr, tbl[i].data, tbl[i].tag, 20, ok);
      chk("tbl_accept", ok, 1);
      if (!tbl[i].we) begin
        get_resp(1, r, t);
        chk("tbl_resp", r, tbl[i].exp_resp);
        chk("tbl_resptag", t, tbl[i].tag);
      end
    end
    wait_idle("tbl_drain");

    // Ten writes with immediate ack, crossing the pointer wrap twice
    mem_lat = 1;
    mem_log.delete();
    for (int i = 0; i < 10; i++) begin
      send(64'h7000 + 64'(8 * i), {32'hC0DE_0000 + 32'(i), 32'(i)}, 10'h200, 20, ok);
      chk("wrap_acc", ok, 1);
    end
    wait_idle("wrap_drain");
    chk("wrap_log_n", mem_log.size(), 10);
    for (int i = 0; i < 10 && i < mem_log.size(); i++) begin
      chk("wrap_addr", mem_log[i].addr, 64'h7000 + 64'(8 * i));
      chk("wrap_data", mem_log[i].data, {32'hC0DE_0000 + 32'(i), 32'(i)});
    end

    // Randomized traffic against a core-side memory image
    mem_log.delete();
    for (int n = 0; n < 60; n++) begin
      mem_lat = $urandom_range(1, 3);
      a = 64'h100 + 64'(8 * $urandom_range(0, 3));
      d = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        send(a, d, {1'b1, 9'($urandom)}, 20, ok);
        chk("rnd_wr_acc", ok, 1);
        ref_mem[a] = d;
        exp_wr.push_back(a);
        exp_wr.push_back(d);
      end else begin
        t = {1'b0, 9'($urandom)};
        send(a, 64'h0, t, 20, ok);
        chk("rnd_rd_acc", ok, 1);
        exp = ref_mem.exists(a) ? ref_mem[a] : (a ^ KDEF);
        d = {54'h0, t};
        get_resp($urandom_range(0, 2), r, t);
        chk("rnd_resp", r, exp);
        chk("rnd_resptag", t, d);
      end
      for (int k = $urandom_range(0, 2); k > 0; k--) tick();
    end
    wait_idle("rnd_drain");
    foreach (mem_log[i]) begin
      if (mem_log[i].we) begin
        got_wr.push_back(mem_log[i].addr);
        got_wr.push_back(mem_log[i].data);
      end
    end
    chk("rnd_wr_count", got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      chk("rnd_wr_seq", got_wr[i], exp_wr[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_core_responder.md
# dcache_core_responder

Responder end of the core-to-data-cache request bus: accepts the write requests the WriteBack stage issues (and loads from the memory stages), acknowledges them with a single-cycle `reqack`, queues writes in a posted write buffer, and drains them to the memory port. Reads are ordered behind all buffered writes, fetched over the same memory port, and returned on a held response channel. It sits between the core's data-side bus and the memory/L2 port.

## Interface
- `DEPTH`, 4, write-buffer entries (power of two, >= 2)
- `TAG_W`, 10, request tag width; bit `TAG_W-1` = WRITE(1)/READ(0), bit `TAG_W-2` = MEMORY, bit `TAG_W-3` = DATA, rest = id
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `reqcyc`  in  1  core request valid, held until `reqack` is seen
- `req`  in  64  request address
- `reqdata`  in  64  write data (ignored for reads)
- `reqtag`  in  TAG_W  request tag
- `reqack`  out  1  one-cycle accept pulse
- `respcyc`  out  1  read response valid, held until `respack`
- `resp`  out  64  read data
- `resptag`  out  TAG_W  tag of the read being answered
- `respack`  in  1  core consumed response
- `mem_reqcyc`  out  1  memory request valid
- `mem_addr`  out  64  memory address
- `mem_wdata`  out  64  memory write data
- `mem_we`  out  1  1 = write, 0 = read
- `mem_ack`  in  1  one-cycle memory completion; `mem_rdata` valid with it for reads
- `mem_rdata`  in  64  memory read data
- `wbuf_count`  out  $clog2(DEPTH+1)  buffered writes
- `wbuf_full`  out  1  `wbuf_count == DEPTH`

## Operation
- Acceptance: request sampled with `reqcyc=1` and `reqack=0` is accepted if (write and buffer not full and FSM in IDLE) or (read and FSM in IDLE). `reqack=1` the following cycle, for exactly one cycle. `reqcyc` sampled while `reqack=1` is ignored (requester drops it on that edge).
- Full: write not accepted, no `reqack`; requester keeps `reqcyc` high; accepted on the first edge where count < DEPTH (count after any same-cycle pop is not used; a pop frees the slot one cycle later).
- Write buffer: FIFO of {addr, data}; push on accept, pop on `mem_ack` for a write. Pointers wrap modulo DEPTH.
- Drain engine: when buffer non-empty, mem port idle and FSM not in RD_MEM, drive head entry with `mem_we=1`, hold `mem_reqcyc` until `mem_ack`; deassert the cycle after `mem_ack`; at least one idle cycle between memory transactions.
- Read FSM: IDLE -> RD_DRAIN on read accept (latch addr, tag). RD_DRAIN -> RD_MEM when buffer empty and mem port idle. RD_MEM: `mem_reqcyc=1`, `mem_we=0`; on `mem_ack` capture `mem_rdata` -> RESP. RESP: `respcyc=1`, `resp`, `resptag` stable; on `respack` -> IDLE.
- Writes are not accepted while FSM != IDLE (strict ordering, no forwarding).
- Only the WRITE bit of `reqtag` is decoded; other bits passed through to `resptag`.

## Timing
- Reset (and reset mid-transaction): all outputs 0, buffer emptied (pending writes discarded), FSM IDLE, in-flight memory request abandoned.
- Write accept latency: `reqcyc` sampled at edge N -> `reqack` high in cycle N+1; `wbuf_count` increments visible N+1.
- Write to memory, empty buffer: `mem_reqcyc` rises cycle N+1 (same cycle as `reqack`).
- Read, empty buffer, memory acks after k request cycles: `reqack` N+1, `mem_reqcyc` N+2..N+1+k, `respcyc` from N+2+k.
- `respcyc` with `respack` same cycle: drop next cycle; new request acceptable that edge (FSM returns IDLE).
- `mem_ack` while `mem_reqcyc=0`: ignored.

## Test plan
- Single write addr 0x1000 data 0xDEADBEEF_00000001: `reqack` one cycle after `reqcyc`; `mem_reqcyc`/`mem_we=1` with same addr/data; `wbuf_count` 1 -> 0 after `mem_ack`.
- Five back-to-back writes, memory ack held off: four acked, fifth holds `reqcyc` with no `reqack` and `wbuf_full=1`; after first `mem_ack`, fifth acked; memory sees all five in order.
- Two writes to 0x2000 then read 0x2000: read acked, no `mem_we=0` request until buffer empty; `resp` returns `mem_rdata`, `resptag` equals read tag id 0x15.
- Read response with `respack` delayed 3 cycles: `respcyc`, `resp`, `resptag` stable throughout; write request in that window not acked until after `respack`.
- `reset` asserted with 3 buffered writes and read in RD_DRAIN: next cycle all outputs 0, `wbuf_count=0`, no further memory requests.
- Wrap-around: 10 sequential writes with immediate `mem_ack`: addresses/data exit in order across pointer wrap.
